// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bus between the config register stage and the timing generator.
//   master : drives Load_config and the resolution parameters, receives syncs/enable/coords/Cfg_err
//   slave  : the timing generator side
//   VGA_FRAME_PULSE_EN adds Frame_start (slave output).
interface vga_timing_gen_if #(
    parameter int PULSE_WIDTH   = 8,
    parameter int REZ_MAX_WIDTH = 11,
    parameter int MARGIN_WIDTH  = 8
);
    logic                     Load_config;
    logic [PULSE_WIDTH-1:0]   H_sync_pulse, V_sync_pulse;
    logic [REZ_MAX_WIDTH-1:0] H_count_max, V_count_max;
    logic [MARGIN_WIDTH-1:0]  H_left_margin, V_left_margin;
    logic [MARGIN_WIDTH-1:0]  H_right_margin, V_right_margin;
    logic                     H_sync_n, V_sync_n, Display_en, Cfg_err;
    logic [REZ_MAX_WIDTH-1:0] Pixel_x, Pixel_y;
`ifdef VGA_FRAME_PULSE_EN
    logic                     Frame_start;
`endif

    modport master (
        output Load_config, H_sync_pulse, V_sync_pulse, H_count_max, V_count_max,
               H_left_margin, V_left_margin, H_right_margin, V_right_margin,
        input  H_sync_n, V_sync_n, Display_en, Pixel_x, Pixel_y, Cfg_err
`ifdef VGA_FRAME_PULSE_EN
        , input Frame_start
`endif
    );

    modport slave (
        input  Load_config, H_sync_pulse, V_sync_pulse, H_count_max, V_count_max,
               H_left_margin, V_left_margin, H_right_margin, V_right_margin,
        output H_sync_n, V_sync_n, Display_en, Pixel_x, Pixel_y, Cfg_err
`ifdef VGA_FRAME_PULSE_EN
        , output Frame_start
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: shadowed-config H/V raster counter with registered sync/enable/coordinate outputs.
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : vga_timing_gen_if.slave (config + load strobe in; syncs, Display_en, Pixel_x/y, Cfg_err out)
//   VGA_FRAME_PULSE_EN : adds Frame_start, high while outputs describe (0,0) in RUN.
module vga_timing_gen #(
    parameter int PULSE_WIDTH   = 8,
    parameter int REZ_MAX_WIDTH = 11,
    parameter int MARGIN_WIDTH  = 8
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.slave  bus
);
    localparam int W = REZ_MAX_WIDTH + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state_q, state_d;
    logic [PULSE_WIDTH-1:0]   hs_q, hs_d, vs_q, vs_d;
    logic [MARGIN_WIDTH-1:0]  hl_q, hl_d, hr_q, hr_d, vl_q, vl_d, vr_q, vr_d;
    logic [REZ_MAX_WIDTH-1:0] hmax_q, hmax_d, vmax_q, vmax_d;
    logic [REZ_MAX_WIDTH-1:0] h_q, h_d, v_q, v_d;
    logic                     err_q, err_d, legal, run, h_wrap;
    logic [W-1:0]             hpre, vpre, hend, vend;
    logic                     hact, vact;
    logic                     hsn_q, hsn_d, vsn_q, vsn_d, de_q, de_d;
    logic [REZ_MAX_WIDTH-1:0] px_q, px_d, py_q, py_d;

    always_comb begin
        legal = (W'(bus.H_sync_pulse) + W'(bus.H_left_margin) + W'(bus.H_right_margin) < W'(bus.H_count_max))
             && (W'(bus.V_sync_pulse) + W'(bus.V_left_margin) + W'(bus.V_right_margin) < W'(bus.V_count_max))
             && (|bus.H_count_max[REZ_MAX_WIDTH-1:1]) && (|bus.V_count_max[REZ_MAX_WIDTH-1:1])
             && (|bus.H_sync_pulse) && (|bus.V_sync_pulse);
        state_d = state_q;
        err_d   = err_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        hl_d    = hl_q;
        hr_d    = hr_q;
        vl_d    = vl_q;
        vr_d    = vr_q;
        hmax_d  = hmax_q;
        vmax_d  = vmax_q;
        h_d     = '0;
        v_d     = '0;
        h_wrap  = h_q == hmax_q - 1'b1;
        if (bus.Load_config) begin
            hs_d    = bus.H_sync_pulse;
            vs_d    = bus.V_sync_pulse;
            hl_d    = bus.H_left_margin;
            hr_d    = bus.H_right_margin;
            vl_d    = bus.V_left_margin;
            vr_d    = bus.V_right_margin;
            hmax_d  = bus.H_count_max;
            vmax_d  = bus.V_count_max;
            state_d = legal ? RUN : IDLE;
            err_d   = !legal;
        end else if (state_q == RUN) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            v_d = h_wrap ? ((v_q == vmax_q - 1'b1) ? '0 : v_q + 1'b1) : v_q;
        end
    end

    // Outputs are decoded from the next-state counters and config so they register in step with them.
    always_comb begin
        run   = state_d == RUN;
        hpre  = W'(hs_d) + W'(hl_d);
        vpre  = W'(vs_d) + W'(vl_d);
        hend  = W'(hmax_d) - W'(hr_d);
        vend  = W'(vmax_d) - W'(vr_d);
        hact  = W'(h_d) >= hpre && W'(h_d) < hend;
        vact  = W'(v_d) >= vpre && W'(v_d) < vend;
        hsn_d = !(run && W'(h_d) < W'(hs_d));
        vsn_d = !(run && W'(v_d) < W'(vs_d));
        de_d  = run && hact && vact;
        px_d  = de_d ? REZ_MAX_WIDTH'(W'(h_d) - hpre) : '0;
        py_d  = de_d ? REZ_MAX_WIDTH'(W'(v_d) - vpre) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            hs_q    <= '0;
            vs_q    <= '0;
            hl_q    <= '0;
            hr_q    <= '0;
            vl_q    <= '0;
            vr_q    <= '0;
            hmax_q  <= '0;
            vmax_q  <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsn_q   <= 1'b1;
            vsn_q   <= 1'b1;
            de_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            hl_q    <= hl_d;
            hr_q    <= hr_d;
            vl_q    <= vl_d;
            vr_q    <= vr_d;
            hmax_q  <= hmax_d;
            vmax_q  <= vmax_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsn_q   <= hsn_d;
            vsn_q   <= vsn_d;
            de_q    <= de_d;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end

    assign bus.H_sync_n   = hsn_q;
    assign bus.V_sync_n   = vsn_q;
    assign bus.Display_en = de_q;
    assign bus.Pixel_x    = px_q;
    assign bus.Pixel_y    = py_q;
    assign bus.Cfg_err    = err_q;

`ifdef VGA_FRAME_PULSE_EN
    logic fs_q, fs_d;
    always_comb fs_d = run && h_d == '0 && v_d == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fs_q <= 1'b0;
        else     fs_q <= fs_d;
    end
    assign bus.Frame_start = fs_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed + randomized check of vga_timing_gen against a frame-time reference model.
module tb_vga_timing_gen;
    localparam int PW = 8, RW = 11, MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.PULSE_WIDTH(PW), .REZ_MAX_WIDTH(RW), .MARGIN_WIDTH(MW)) bus();
    vga_timing_gen #(.PULSE_WIDTH(PW), .REZ_MAX_WIDTH(RW), .MARGIN_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk = 0, n_pass = 0;

    // Model: clocks elapsed since the last legal load; h/v follow by division.
    bit m_run = 0, m_err = 0;
    int m_t = 0;
    int cHm, cHS, cHL, cHR, cVm, cVS, cVL, cVR;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    endtask

    task automatic set_cfg(input int hm, hs, hl, hr, vm, vs, vl, vr);
        bus.H_count_max    = RW'(hm);
        bus.H_sync_pulse   = PW'(hs);
        bus.H_left_margin  = MW'(hl);
        bus.H_right_margin = MW'(hr);
        bus.V_count_max    = RW'(vm);
        bus.V_sync_pulse   = PW'(vs);
        bus.V_left_margin  = MW'(vl);
        bus.V_right_margin = MW'(vr);
    endtask

    function automatic int cur_h();
        return m_run ? m_t % cHm : 0;
    endfunction

    function automatic int cur_v();
        return m_run ? (m_t / cHm) % cVm : 0;
    endfunction

    function automatic bit exp_de();
        int h = cur_h(), v = cur_v();
        return m_run && h >= cHS + cHL && h < cHm - cHR && v >= cVS + cVL && v < cVm - cVR;
    endfunction

    task automatic check_all();
        int h = cur_h(), v = cur_v();
        bit de = exp_de();
        chk("H_sync_n", int'(bus.H_sync_n), (m_run && h < cHS) ? 0 : 1);
        chk("V_sync_n", int'(bus.V_sync_n), (m_run && v < cVS) ? 0 : 1);
        chk("Display_en", int'(bus.Display_en), int'(de));
        chk("Pixel_x", int'(bus.Pixel_x), de ? h - cHS - cHL : 0);
        chk("Pixel_y", int'(bus.Pixel_y), de ? v - cVS - cVL : 0);
        chk("Cfg_err", int'(bus.Cfg_err), int'(m_err));
`ifdef VGA_FRAME_PULSE_EN
        chk("Frame_start", int'(bus.Frame_start), (m_run && h == 0 && v == 0) ? 1 : 0);
`endif
    endtask

    task automatic cyc(input bit ld);
        bus.Load_config = ld;
        @(posedge clk);
        if (ld) begin
            cHm = int'(bus.H_count_max);   cHS = int'(bus.H_sync_pulse);
            cHL = int'(bus.H_left_margin); cHR = int'(bus.H_right_margin);
            cVm = int'(bus.V_count_max);   cVS = int'(bus.V_sync_pulse);
            cVL = int'(bus.V_left_margin); cVR = int'(bus.V_right_margin);
            m_run = cHS + cHL + cHR < cHm && cVS + cVL + cVR < cVm
                 && cHm >= 2 && cVm >= 2 && cHS >= 1 && cVS >= 1;
            m_err = !m_run;
            m_t = 0;
        end else if (m_run) begin
            m_t++;
        end
        @(negedge clk);
        check_all();
    endtask

    // 3 ns asynchronous reset pulse between clock edges, checked before any edge.
    task automatic rst_pulse();
        rst = 1'b1;
        m_run = 0;
        m_err = 0;
        m_t = 0;
        #1 check_all();
        #2 rst = 1'b0;
    endtask

    initial begin
        int guard;
        bus.Load_config = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;
        repeat (20) cyc(0);

        set_cfg(10, 2, 1, 2, 6, 1, 1, 1);
        cyc(1);
        repeat (130) cyc(0);

        guard = 0;
        while (!(cur_h() == 5 && cur_v() == 3) && guard < 100) begin
            cyc(0);
            guard++;
        end
        chk("reach_h5v3", guard < 100 ? 1 : 0, 1);
        set_cfg(12, 3, 1, 2, 6, 1, 1, 1);
        cyc(1);
        chk("reload_hsync", int'(bus.H_sync_n), 0);
        repeat (90) cyc(0);

        set_cfg(10, 4, 3, 3, 6, 1, 1, 1);
        cyc(1);
        chk("illegal_err", int'(bus.Cfg_err), 1);
        repeat (20) cyc(0);
        set_cfg(10, 2, 1, 2, 6, 1, 1, 1);
        cyc(1);
        chk("legal_clears_err", int'(bus.Cfg_err), 0);

        guard = 0;
        while (!exp_de() && guard < 100) begin
            cyc(0);
            guard++;
        end
        chk("reach_active", int'(bus.Display_en), 1);
        rst_pulse();
        repeat (15) cyc(0);

        set_cfg(10, 2, 1, 2, 6, 1, 1, 1);
        repeat (4) cyc(1);
        repeat (30) cyc(0);

        for (int k = 0; k < 40; k++) begin
            int hm = $urandom_range(2, 30);
            int vm = $urandom_range(2, 12);
            set_cfg(hm, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                    vm, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            repeat ($urandom_range(1, 2)) cyc(1);
            repeat ($urandom_range(1, hm * vm * 2)) cyc(0);
            if ($urandom_range(0, 7) == 0) begin
                rst_pulse();
                repeat (3) cyc(0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
